// File: rtl/dmem_responder.sv
// Data-port memory responder: word-addressed RAM plus MMIO (LED, cycle counter, compare, status).
// Optional macro DMEM_ALIGN_CHECK_EN rejects irregular byte-enable patterns and flags them on align_err.
module dmem_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  memwen,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] led,
    output logic        irq,
    output logic        align_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       count;
    logic [31:0]       cmp;
    logic              match;
    logic              ram_sel;
    logic              mmio_sel;
    logic [ADDR_W-1:0] word_idx;
    reg_e              reg_sel;
    logic              wr_en;
    logic              illegal;
    logic              addr_unused;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    logic align_q;

    // Only single bytes, aligned halfwords and full words are accepted.
    function automatic logic enable_legal(input logic [3:0] lanes);
        case (lanes)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign illegal   = (memwen != 4'b0000) && !enable_legal(memwen);
    assign align_err = align_q;
`else
    assign illegal   = 1'b0;
    assign align_err = 1'b0;
`endif

    // Offset bits [1:0] and RAM alias bits do not participate in decode.
    assign addr_unused = ^addr;

    always_comb begin
        ram_sel  = (addr[31:16] == 16'h0000);
        mmio_sel = (addr[31:4] == MMIO_BASE[31:4]);
        word_idx = addr[ADDR_W+1:2];
        reg_sel  = reg_e'(addr[3:2]);
        wr_en    = (memwen != 4'b0000) && !illegal;
    end

    always_comb begin
        readdata = 32'h0000_0000;
        if (ram_sel) begin
            readdata = mem[word_idx];
        end else if (mmio_sel) begin
            case (reg_sel)
                REG_LED:    readdata = led;
                REG_COUNT:  readdata = count;
                REG_CMP:    readdata = cmp;
                REG_STATUS: readdata = {30'd0, align_err, match};
                default:    readdata = 32'h0000_0000;
            endcase
        end
    end

    // RAM is not reset, and a store coinciding with rst still lands.
    always_ff @(posedge clk) begin
        if (wr_en && ram_sel) begin
            mem[word_idx] <= lane_merge(mem[word_idx], writedata, memwen);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led   <= 32'h0000_0000;
            count <= 32'h0000_0000;
            cmp   <= 32'hFFFF_FFFF;
            match <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
        end else begin
            count <= count + 32'd1;
            if (wr_en && mmio_sel) begin
                case (reg_sel)
                    REG_LED:   led   <= lane_merge(led, writedata, memwen);
                    REG_COUNT: count <= lane_merge(count, writedata, memwen);
                    REG_CMP:   cmp   <= lane_merge(cmp, writedata, memwen);
                    REG_STATUS: begin
                        if (memwen[0] && writedata[0]) match <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
                        if (memwen[0] && writedata[1]) align_q <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
            // Later assignments win: a set beats a same-edge W1C clear.
            if (count == cmp) match <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
            if (illegal) align_q <= 1'b1;
`endif
        end
    end

    assign irq = match;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder at the far end of the CPU core's data port: takes byte write enables, address and write data, and returns read data the same cycle.
- Decodes two regions:
  - a word-addressed RAM;
  - a small MMIO block with an LED register, a free-running cycle counter, a compare register and a sticky match/interrupt flag.
- Sits beside the core in the SoC top, wired directly to the core's memwen/aluout/writedata/readdata.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words (1024 words).
- MMIO_BASE, 32'h0001_0000, base byte address of the MMIO block (16-byte window).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- memwen  input  4  byte write enables; bit i writes byte lane i (bits [8i+7:8i])
- addr  input  32  byte address from core (aluout)
- writedata  input  32  store data, already lane-replicated by core
- readdata  output  32  load data, combinational from addr
- led  output  32  LED register value
- irq  output  1  compare-match flag (sticky)
- align_err  output  1  sticky illegal-enable flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Address decode:
  - RAM when addr[31:16]==16'h0000; word index addr[ADDR_W+1:2]; upper bits above the index are ignored, so access aliases modulo depth.
  - MMIO when addr[31:4]==MMIO_BASE[31:4].
  - Anything else is unmapped: reads return 0, writes are dropped.
- addr[1:0] are ignored for decode; the core selects lanes via memwen.
- Reads:
  - readdata is combinational from the current addr; there is no read strobe, and reads have no side effects.
  - Read of a location written in the same cycle returns the old value. New data is visible from the cycle after the write edge.
- Writes: performed at posedge clk when memwen!=0, per-lane merge into the target word. No write-back latency beyond that edge.
- MMIO registers:
  - +0x0 LED: R/W, lane-merged.
  - +0x4 COUNT: increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0. On a write cycle the lane-merged write value is loaded instead of incrementing (no +1 that cycle).
  - +0x8 CMP: R/W, lane-merged.
  - +0xC STATUS: bit0 = match flag, bit1 = align_err, other bits read 0. Writing 1 to lane-0 bit0 clears the match flag (W1C); bit1 is cleared the same way.
- Match:
  - At each edge, if the current COUNT == CMP, the match flag is set at that edge.
  - Set has priority over a simultaneous W1C clear.
  - irq = match flag.
- Reset values:
  - led=0, COUNT=0, CMP=32'hFFFF_FFFF, match=0, align_err=0.
  - RAM contents are not reset.
  - readdata follows decode during and after reset.
- A write in the same cycle as rst: reset wins; the RAM write is still performed, MMIO writes are discarded.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - Legal memwen values are 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other nonzero value drops the whole write (RAM or MMIO) and sets align_err (sticky, W1C via STATUS bit1).
- Undefined:
  - All enable patterns are written as given.
  - align_err is tied 0 and STATUS bit1 reads 0.

Test Plan:
- Write 32'hDEADBEEF to 0x0000_0040 with memwen=1111, then read 0x40 -> 32'hDEADBEEF; then memwen=0010 with writedata=32'h0000_5500 -> read gives 32'hDEAD55EF.
- Same-cycle read/write: write 32'h1 to 0x44 (previously 0); readdata that cycle = 0, next cycle = 1. Read 0x1000+0x44 with ADDR_W=10 -> aliases to 0x44.
- Counter: after rst, read MMIO_BASE+4 on the 5th cycle after reset release -> 4. Write 32'hFFFF_FFFE -> subsequent reads give FFFF_FFFE, FFFF_FFFF, 0.
- Match: write CMP=32'd20 and let the counter run -> irq rises at the edge where COUNT==20. Write STATUS=1 -> irq=0. Issue the W1C on the exact match edge -> irq stays 1.
- Unmapped: write to 0x2000_0000 -> no RAM/MMIO change; read -> 0. LED written 32'hA5 with memwen=0001 -> led=32'h0000_00A5.
- With DMEM_ALIGN_CHECK_EN: memwen=0101 to 0x40 -> RAM unchanged, align_err=1, STATUS reads 32'h2. Without the macro, the same write updates lanes 0 and 2 and align_err=0.
